lcd_frame_arbiter: RTL

Shares the single character-LCD controller between several frame sources, such as the measurement readout and the settings menus. Each source raises a request. The arbiter grants one source round-robin and pulls that source's 32 characters through a read port, writing each into the LCD buffer. It then fires one repaint and waits for the LCD to finish before releasing the grant. It sits between the UI screen generators and the `lcd` driver and replaces ad-hoc output muxing.

---
 rtl/lcd_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/lcd_frame_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Constants and FSM encoding shared by the LCD frame arbiter and the screen generators.
package lcd_pkg;
   localparam int LCD_CHARS  = 32;
   localparam int LCD_ADDR_W = 5;
   localparam int CHAR_W     = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COPY      = 3'd1,
      REPAINT   = 3'd2,
      WAIT_RISE = 3'd3,
      WAIT_FALL = 3'd4
   } lcd_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester above the last-served index, wrapping.
// Zero latency; returns an all-zero grant when nothing requests.
module rr_arbiter #(
   parameter int NREQ  = 2,
   parameter int IDX_W = 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] idx
);
   logic found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (j == (int'(ptr) + k) % NREQ)) begin
               found  = 1'b1;
               gnt[j] = 1'b1;
               idx    = IDX_W'(j);
            end
         end
      end
   end
endmodule

// File: rtl/lcd_frame_arbiter.sv
// Grants one frame source round-robin, copies its 32 characters into the LCD buffer, repaints.
// First write 2 cycles after request; a busy LCD holds off grant and repaint, dropping req abandons.
module lcd_frame_arbiter
   import lcd_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int BUSY_TO = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   output logic [NREQ-1:0]        gnt,
   output logic [LCD_ADDR_W-1:0]  rd_addr,
   input  logic [CHAR_W*NREQ-1:0] rd_data,
   output logic [NREQ-1:0]        done,
   output logic [CHAR_W-1:0]      lcd_dat,
   output logic [LCD_ADDR_W-1:0]  lcd_addr,
   output logic                   lcd_we,
   output logic                   lcd_repaint,
   input  logic                   lcd_busy
);
   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TO_W  = (BUSY_TO > 1) ? $clog2(BUSY_TO + 1) : 1;
   localparam int CNT_W = LCD_ADDR_W + 1;

   lcd_state_e            state_q, state_d;
   logic [NREQ-1:0]       gnt_q, gnt_d, done_q, done_d, pick_gnt;
   logic [IDX_W-1:0]      ptr_q, ptr_d, win_q, win_d, pick_idx;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [LCD_ADDR_W-1:0] rd_addr_q, rd_addr_d, lcd_addr_q, lcd_addr_d;
   logic                  we_q, we_d, repaint_q, repaint_d;
   logic [TO_W-1:0]       to_q, to_d;
   logic [CHAR_W-1:0]     slice;
   logic                  abandon;

   rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
      .req (req),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   // Sources return registered data, so the write lags rd_addr by one cycle.
   always_comb begin
      slice = '0;
      for (int i = 0; i < NREQ; i++) begin
         slice = slice | (rd_data[i*CHAR_W +: CHAR_W] & {CHAR_W{gnt_q[i]}});
      end
   end

   assign abandon = ~|(req & gnt_q);

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      ptr_d      = ptr_q;
      win_d      = win_q;
      cnt_d      = cnt_q;
      rd_addr_d  = rd_addr_q;
      lcd_addr_d = lcd_addr_q;
      to_d       = to_q;
      we_d       = 1'b0;
      repaint_d  = 1'b0;
      done_d     = '0;
      case (state_q)
         IDLE: begin
            if (|req && !lcd_busy) begin
               gnt_d     = pick_gnt;
               win_d     = pick_idx;
               rd_addr_d = '0;
               cnt_d     = '0;
               state_d   = COPY;
            end
         end
         COPY: begin
            if (abandon) begin
               gnt_d     = '0;
               ptr_d     = win_q;
               rd_addr_d = '0;
               state_d   = IDLE;
            end else if (cnt_q == CNT_W'(LCD_CHARS)) begin
               rd_addr_d = '0;
               state_d   = REPAINT;
            end else begin
               we_d       = 1'b1;
               lcd_addr_d = cnt_q[LCD_ADDR_W-1:0];
               rd_addr_d  = cnt_q[LCD_ADDR_W-1:0] + LCD_ADDR_W'(1);
               cnt_d      = cnt_q + CNT_W'(1);
            end
         end
         REPAINT: begin
            if (abandon) begin
               gnt_d   = '0;
               ptr_d   = win_q;
               state_d = IDLE;
            end else if (!lcd_busy) begin
               repaint_d = 1'b1;
               to_d      = '0;
               state_d   = WAIT_RISE;
            end
         end
         WAIT_RISE: begin
            if (abandon) begin
               gnt_d   = '0;
               ptr_d   = win_q;
               state_d = IDLE;
            end else if (lcd_busy || to_q == TO_W'(BUSY_TO - 1)) begin
               state_d = WAIT_FALL;
            end else begin
               to_d = to_q + TO_W'(1);
            end
         end
         WAIT_FALL: begin
            // The repaint is committed here, so a dropped request no longer cancels done.
            if (!lcd_busy) begin
               done_d  = gnt_q;
               gnt_d   = '0;
               ptr_d   = win_q;
               state_d = IDLE;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         ptr_q      <= IDX_W'(NREQ - 1);
         win_q      <= '0;
         cnt_q      <= '0;
         rd_addr_q  <= '0;
         lcd_addr_q <= '0;
         to_q       <= '0;
         we_q       <= 1'b0;
         repaint_q  <= 1'b0;
         done_q     <= '0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         ptr_q      <= ptr_d;
         win_q      <= win_d;
         cnt_q      <= cnt_d;
         rd_addr_q  <= rd_addr_d;
         lcd_addr_q <= lcd_addr_d;
         to_q       <= to_d;
         we_q       <= we_d;
         repaint_q  <= repaint_d;
         done_q     <= done_d;
      end
   end

   assign gnt         = gnt_q;
   assign rd_addr     = rd_addr_q;
   assign done        = done_q;
   assign lcd_we      = we_q;
   assign lcd_addr    = lcd_addr_q;
   assign lcd_dat     = we_q ? slice : '0;
   assign lcd_repaint = repaint_q;
endmodule
